apb_slave_regbank: RTL and testbench



---
 rtl/apb_pkg.sv | 31 +++
 rtl/apb_wait_counter.sv | 42 ++++
 rtl/apb_slave_regbank.sv | 184 ++++++++++++++++++
 tb/tb_apb_slave_regbank.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB register-bank completer:
//   - bus widths
//   - FSM state encoding
//   - wait-counter width
//   - word-alignment helper
// -----------------------------------------------------------------------------
package apb_pkg;

    localparam int APB_DATA_W = 32;
    localparam int APB_ADDR_W = 32;

    // Number of byte-offset bits below a 32-bit word index.
    localparam int WORD_LSB = 2;

    // Width of the wait-state counter (supports 0..15 wait states).
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } apb_state_e;

    // True when the byte-offset bits of an address select a whole word.
    function automatic logic is_word_aligned(input logic [WORD_LSB-1:0] byte_off);
        return (byte_off == {WORD_LSB{1'b0}});
    endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// -----------------------------------------------------------------------------
// apb_wait_counter
// Loadable down-counter that times the APB wait states.
// Decrementing stops at zero.
// Ports:
//   pclk     - clock
//   preset   - asynchronous active-low reset, clears the count
//   load     - load load_val (has priority over en)
//   load_val - value to load
//   en       - decrement enable
//   zero     - count is 0
//   last     - count is 1; the next enabled decrement reaches zero
// -----------------------------------------------------------------------------
module apb_wait_counter
    import apb_pkg::*;
(
    input  logic             pclk,
    input  logic             preset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero,
    output logic             last
);

    logic [CNT_W-1:0] count_r;

    // Count register: load, or decrement while enabled and non-zero.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (en && (count_r != {CNT_W{1'b0}})) begin
            count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign zero = (count_r == {CNT_W{1'b0}});
    assign last = (count_r == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/apb_slave_regbank.sv
// -----------------------------------------------------------------------------
// apb_slave_regbank
// APB completer holding NUM_REGS 32-bit read/write registers.
// Each access is stretched by WAIT_CYCLES wait states.
// Out-of-range or misaligned addresses complete with pslverr.
// All outputs are registered.
// Ports:
//   pclk    - APB clock
//   preset  - asynchronous active-low reset
//   psel    - slave select
//   penable - access-phase strobe
//   pwrite  - 1 = write, 0 = read
//   paddr   - byte address
//   pwdata  - write data
//   prdata  - read data (valid with pready on a read; holds otherwise)
//   pready  - one-cycle transfer completion
//   pslverr - error flag, only ever high together with pready
// -----------------------------------------------------------------------------
module apb_slave_regbank
    import apb_pkg::*;
#(
    parameter int              NUM_REGS    = 16,
    parameter logic [31:0]     BASE_ADDR   = 32'h0000_0000,
    parameter int              WAIT_CYCLES = 2
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [APB_ADDR_W-1:0] paddr,
    input  logic [APB_DATA_W-1:0] pwdata,
    output logic [APB_DATA_W-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int               IDX_W    = $clog2(NUM_REGS);
    localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(WAIT_CYCLES);
    localparam logic [29:0]      NUM_REGS_W = 30'(NUM_REGS);

    apb_state_e state_r;
    apb_state_e state_s;

    // Registers of the transfer accepted in the last setup phase.
    logic                  write_r;
    logic                  valid_r;
    logic [IDX_W-1:0]      idx_r;
    logic [APB_DATA_W-1:0] wdata_r;

    logic [APB_DATA_W-1:0] prdata_r;
    logic                  pready_r;
    logic                  pslverr_r;

    logic [APB_DATA_W-1:0] regs_r [NUM_REGS];

    logic                  setup_s;
    logic [APB_ADDR_W-1:0] offset_s;
    logic                  valid_s;
    logic [IDX_W-1:0]      idx_s;

    logic                  take_s;
    logic                  cnt_load_s;
    logic                  cnt_en_s;
    logic                  cnt_zero_s;
    logic                  cnt_last_s;

    logic                  complete_s;
    logic                  cur_write_s;
    logic                  cur_valid_s;
    logic [IDX_W-1:0]      cur_idx_s;
    logic [APB_DATA_W-1:0] cur_wdata_s;

    // Address decode; the subtraction wraps so addresses below BASE_ADDR land far out of range.
    assign setup_s  = psel & ~penable;
    assign offset_s = paddr - BASE_ADDR;
    assign valid_s  = is_word_aligned(offset_s[WORD_LSB-1:0]) &&
                      (offset_s[APB_ADDR_W-1:WORD_LSB] < NUM_REGS_W);
    assign idx_s    = offset_s[IDX_W+WORD_LSB-1:WORD_LSB];

    apb_wait_counter u_wait_counter (
        .pclk     (pclk),
        .preset   (preset),
        .load     (cnt_load_s),
        .load_val (WAIT_LD),
        .en       (cnt_en_s),
        .zero     (cnt_zero_s),
        .last     (cnt_last_s)
    );

    // Next-state logic. The WAIT to DONE step happens on the same edge the counter reaches 0.
    always_comb begin
        state_s    = state_r;
        take_s     = 1'b0;
        cnt_load_s = 1'b0;
        cnt_en_s   = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (setup_s) begin
                    take_s     = 1'b1;
                    cnt_load_s = 1'b1;
                    state_s    = (WAIT_LD == {CNT_W{1'b0}}) ? DONE : WAIT;
                end else begin
                    state_s    = IDLE;
                end
            end
            WAIT: begin
                if (!psel) begin
                    // Master abandoned the transfer: no completion, no write.
                    state_s = IDLE;
                end else begin
                    cnt_en_s = 1'b1;
                    if (cnt_last_s || cnt_zero_s) begin
                        state_s = DONE;
                    end else begin
                        state_s = WAIT;
                    end
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // With zero wait states a transfer completes on its own setup edge, so use the live bus then.
    assign complete_s  = (state_s == DONE);
    assign cur_write_s = take_s ? pwrite  : write_r;
    assign cur_valid_s = take_s ? valid_s : valid_r;
    assign cur_idx_s   = take_s ? idx_s   : idx_r;
    assign cur_wdata_s = take_s ? pwdata  : wdata_r;

    // State, latched transfer and registered bus responses.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state_r   <= IDLE;
            write_r   <= 1'b0;
            valid_r   <= 1'b0;
            idx_r     <= {IDX_W{1'b0}};
            wdata_r   <= {APB_DATA_W{1'b0}};
            prdata_r  <= {APB_DATA_W{1'b0}};
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            pready_r <= complete_s;
            if (take_s) begin
                write_r <= pwrite;
                valid_r <= valid_s;
                idx_r   <= idx_s;
                wdata_r <= pwdata;
            end
            if (complete_s) begin
                if (cur_valid_s) begin
                    pslverr_r <= 1'b0;
                    if (!cur_write_s) begin
                        prdata_r <= regs_r[cur_idx_s];
                    end
                end else begin
                    pslverr_r <= 1'b1;
                    prdata_r  <= {APB_DATA_W{1'b0}};
                end
            end else begin
                pslverr_r <= 1'b0;
            end
        end
    end

    // Register array, written on the edge that raises pready for a valid write.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {APB_DATA_W{1'b0}};
            end
        end else if (complete_s && cur_valid_s && cur_write_s) begin
            regs_r[cur_idx_s] <= cur_wdata_s;
        end
    end

    assign prdata  = prdata_r;
    assign pready  = pready_r;
    assign pslverr = pslverr_r;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_regbank
// Directed bench for apb_slave_regbank.
// Two instances share one APB bus:
//   - dut0: WAIT_CYCLES = 2
//   - dut1: WAIT_CYCLES = 0
// Each scenario task drives its own transfers and checks the results inline.
// -----------------------------------------------------------------------------
module tb_apb_slave_regbank;

    logic        pclk;
    logic        preset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata0;
    logic [31:0] prdata1;
    logic        pready0;
    logic        pready1;
    logic        pslverr0;
    logic        pslverr1;

    int checks;
    int failures;

    apb_slave_regbank #(
        .NUM_REGS    (16),
        .BASE_ADDR   (32'h0000_0000),
        .WAIT_CYCLES (2)
    ) dut0 (
        .pclk    (pclk),
        .preset  (preset),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata0),
        .pready  (pready0),
        .pslverr (pslverr0)
    );

    apb_slave_regbank #(
        .NUM_REGS    (16),
        .BASE_ADDR   (32'h0000_0000),
        .WAIT_CYCLES (0)
    ) dut1 (
        .pclk    (pclk),
        .preset  (preset),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata1),
        .pready  (pready1),
        .pslverr (pslverr1)
    );

    // 10 ns clock.
    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // One complete transfer on the selected instance.
    // lat counts clock edges from the setup edge up to the edge that raised pready.
    // It stops at 20 if pready never comes.
    task automatic xfer(input bit sel1, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic err, output int lat);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        @(posedge pclk); #1;
        penable = 1'b1;
        lat = 1;
        while (!(sel1 ? pready1 : pready0) && lat < 20) begin
            @(posedge pclk); #1;
            lat++;
        end
        rd  = sel1 ? prdata1 : prdata0;
        err = sel1 ? pslverr1 : pslverr0;
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic err; int lat;
        preset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0;
        repeat (3) @(posedge pclk);
        #1 preset = 1'b1;
        @(posedge pclk); #1;
        checks++; if (pready0 !== 1'b0) begin failures++; $display("FAIL reset_pready got=%b exp=0", pready0); end
        checks++; if (pslverr0 !== 1'b0) begin failures++; $display("FAIL reset_pslverr got=%b exp=0", pslverr0); end
        checks++; if (prdata0 !== 32'h0) begin failures++; $display("FAIL reset_prdata got=%h exp=0", prdata0); end
        checks++; if (pready1 !== 1'b0) begin failures++; $display("FAIL reset_pready1 got=%b exp=0", pready1); end
        xfer(1'b0, 1'b0, 32'h08, 32'h0, rd, err, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL reset_read_lat got=%0d exp=3", lat); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_read_data got=%h exp=0", rd); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_read_err got=%b exp=0", err); end
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic err; int lat;
        xfer(1'b0, 1'b1, 32'h0C, 32'hDEAD_BEEF, rd, err, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL wr_lat got=%0d exp=3", lat); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL wr_err got=%b exp=0", err); end
        checks++; if (pready0 !== 1'b0) begin failures++; $display("FAIL wr_pready_one_cycle got=%b exp=0", pready0); end
        xfer(1'b0, 1'b0, 32'h0C, 32'h0, rd, err, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL rd_lat got=%0d exp=3", lat); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rd_err got=%b exp=0", err); end
        // Highest valid register.
        xfer(1'b0, 1'b1, 32'h3C, 32'h0BAD_F00D, rd, err, lat);
        xfer(1'b0, 1'b0, 32'h3C, 32'h0, rd, err, lat);
        checks++; if (rd !== 32'h0BAD_F00D) begin failures++; $display("FAIL top_reg_data got=%h exp=0badf00d", rd); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL top_reg_err got=%b exp=0", err); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int lat;
        xfer(1'b0, 1'b1, 32'h40, 32'h0000_1234, rd, err, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL oor_lat got=%0d exp=3", lat); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL oor_err got=%b exp=1", err); end
        checks++; if (pslverr0 !== 1'b0) begin failures++; $display("FAIL oor_err_clear got=%b exp=0", pslverr0); end
        // idx 16 must not alias onto register 0.
        xfer(1'b0, 1'b0, 32'h00, 32'h0, rd, err, lat);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL oor_no_alias got=%h exp=0", rd); end
        xfer(1'b0, 1'b0, 32'h0C, 32'h0, rd, err, lat);
        checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL oor_reg_kept got=%h exp=deadbeef", rd); end
        xfer(1'b0, 1'b0, 32'h06, 32'h0, rd, err, lat);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL misalign_err got=%b exp=1", err); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL misalign_data got=%h exp=0", rd); end
        xfer(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, rd, err, lat);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL wrap_addr_err got=%b exp=1", err); end
    endtask

    task automatic test_back_to_back();
        int lat;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h00; pwdata = 32'h5;
        @(posedge pclk); #1;
        penable = 1'b1; lat = 1;
        while (!pready0 && lat < 20) begin @(posedge pclk); #1; lat++; end
        checks++; if (lat !== 3) begin failures++; $display("FAIL b2b_wr_lat got=%0d exp=3", lat); end
        // New setup phase during the pready cycle.
        penable = 1'b0; pwrite = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1; lat = 1;
        while (!pready0 && lat < 20) begin @(posedge pclk); #1; lat++; end
        checks++; if (lat !== 3) begin failures++; $display("FAIL b2b_rd_lat got=%0d exp=3", lat); end
        checks++; if (prdata0 !== 32'h5) begin failures++; $display("FAIL b2b_rd_data got=%h exp=5", prdata0); end
        checks++; if (pslverr0 !== 1'b0) begin failures++; $display("FAIL b2b_rd_err got=%b exp=0", pslverr0); end
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err; int lat;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'hFFFF_FFFF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b0;
        #1;
        checks++; if (pready0 !== 1'b0) begin failures++; $display("FAIL rstmid_pready got=%b exp=0", pready0); end
        checks++; if (prdata0 !== 32'h0) begin failures++; $display("FAIL rstmid_prdata got=%h exp=0", prdata0); end
        checks++; if (pslverr0 !== 1'b0) begin failures++; $display("FAIL rstmid_pslverr got=%b exp=0", pslverr0); end
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        preset = 1'b1;
        @(posedge pclk); #1;
        xfer(1'b0, 1'b0, 32'h04, 32'h0, rd, err, lat);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rstmid_no_write got=%h exp=0", rd); end
        xfer(1'b0, 1'b0, 32'h00, 32'h0, rd, err, lat);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rstmid_regs_cleared got=%h exp=0", rd); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd; logic err; int lat;
        xfer(1'b1, 1'b1, 32'h3C, 32'hA5A5_A5A5, rd, err, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL zw_wr_lat got=%0d exp=1", lat); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL zw_wr_err got=%b exp=0", err); end
        xfer(1'b1, 1'b0, 32'h3C, 32'h0, rd, err, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL zw_rd_lat got=%0d exp=1", lat); end
        checks++; if (rd !== 32'hA5A5_A5A5) begin failures++; $display("FAIL zw_rd_data got=%h exp=a5a5a5a5", rd); end
        xfer(1'b1, 1'b0, 32'h41, 32'h0, rd, err, lat);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL zw_err got=%b exp=1", err); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic err; int lat;
        int seen;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h77;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge pclk); #1;
            if (pready0 !== 1'b0 || pslverr0 !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL abort_no_ready got=%0d exp=0", seen); end
        xfer(1'b0, 1'b0, 32'h10, 32'h0, rd, err, lat);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL abort_no_write got=%h exp=0", rd); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL abort_recover_lat got=%0d exp=3", lat); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_write_read();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_zero_wait();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
